// File: rtl/image_scan_ctrl.sv
// Image store with a scanning display fetcher (IDLE -> FETCH -> HOLD) and a host write port.
// Define IMAGE_SCAN_WRBYPASS_EN to forward host writes that hit the displayed entry straight into disp_data.
module image_scan_ctrl #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 3,
  parameter int DWELL_CYCLES  = 50000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     scan_en,
  input  logic                     wr_req,
  input  logic [RAM_ADDR_BITS-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0]     wr_data,
  output logic                     wr_ack,
  output logic [RAM_WIDTH-1:0]     disp_data,
  output logic [RAM_ADDR_BITS-1:0] disp_addr,
  output logic                     disp_valid,
  output logic                     frame_done
);

  localparam int                       DEPTH      = 2 ** RAM_ADDR_BITS;
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_LAST  = {RAM_ADDR_BITS{1'b1}};
  localparam logic [15:0]              DWELL_LOAD = 16'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [RAM_ADDR_BITS-1:0] scan_addr;
  logic [15:0]              dwell_cnt;
  logic [RAM_WIDTH-1:0]     mem [DEPTH];

  logic do_fetch;
  logic hold_done;
  logic bypass_hit;

  // Next-state decode; scan_en low overrides everything, host writes pre-empt the fetch read.
  always_comb begin
    state_nxt = state;
    do_fetch  = 1'b0;
    hold_done = 1'b0;
    if (!scan_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = FETCH;
        FETCH: begin
          if (!wr_req) begin
            do_fetch  = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (dwell_cnt == 16'd0) begin
            hold_done = 1'b1;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef IMAGE_SCAN_WRBYPASS_EN
  assign bypass_hit = wr_req && disp_valid && (wr_addr == disp_addr);
`else
  assign bypass_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Scan address and dwell counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_addr <= '0;
      dwell_cnt <= '0;
    end else if (!scan_en) begin
      scan_addr <= '0;
      dwell_cnt <= '0;
    end else begin
      if (hold_done) begin
        scan_addr <= scan_addr + 1'b1;
      end
      if (do_fetch) begin
        dwell_cnt <= DWELL_LOAD;
      end else if (state == HOLD && dwell_cnt != 16'd0) begin
        dwell_cnt <= dwell_cnt - 16'd1;
      end
    end
  end

  // Image store: single port, a write always wins the cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_req) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Display registers; disp_data survives scan_en dropping, only valid is cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_data  <= '0;
      disp_addr  <= '0;
      disp_valid <= 1'b0;
    end else begin
      if (do_fetch) begin
        disp_data <= mem[scan_addr];
        disp_addr <= scan_addr;
      end else if (bypass_hit) begin
        disp_data <= wr_data;
      end
      if (!scan_en) begin
        disp_valid <= 1'b0;
      end else if (do_fetch) begin
        disp_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ack     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr_ack     <= wr_req;
      frame_done <= hold_done && (scan_addr == ADDR_LAST);
    end
  end

endmodule

// File: tb/tb_image_scan_ctrl.sv
// Directed bench for image_scan_ctrl with DWELL_CYCLES=4: table-driven frame scan plus hand sequences.
module tb_image_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scan_en;
  logic       wr_req;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [7:0] disp_data;
  logic [2:0] disp_addr;
  logic       disp_valid;
  logic       frame_done;

  int n_vec  = 0;
  int n_fail = 0;

  image_scan_ctrl #(
    .RAM_WIDTH(8),
    .RAM_ADDR_BITS(3),
    .DWELL_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .scan_en(scan_en),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .disp_data(disp_data),
    .disp_addr(disp_addr),
    .disp_valid(disp_valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       en;
    logic       ev;
    logic [2:0] ea;
    logic [7:0] ed;
    logic       eack;
    logic       efd;
  } vec_t;

  vec_t vecs[50];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, disp_valid, disp_addr, disp_data, wr_ack, frame_done};
  endfunction

  function automatic logic [31:0] pack(logic v, logic [2:0] a, logic [7:0] d, logic ack, logic fd);
    return {19'd0, v, a, d, ack, fd};
  endfunction

  // Reset, then load 0x11..0x88 into addresses 0..7 with scanning off.
  task automatic restart();
    reset_n = 1'b0;
    scan_en = 1'b0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_req  = 1'b1;
      wr_addr = 3'(i);
      wr_data = 8'(17 * (i + 1));
      tick();
    end
    wr_req = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_a5;
    int idx;

    // Frame-scan table: 8 writes, enable, then 8 fetch+4-hold slots and the wrap fetch.
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      vecs[idx] = '{1'b1, 3'(i), 8'(17 * (i + 1)), 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0};
      idx++;
    end
    vecs[idx] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    idx++;
    for (int k = 0; k < 9; k++) begin
      vecs[idx] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'(k % 8), 8'(17 * ((k % 8) + 1)), 1'b0, 1'b0};
      idx++;
      if (k < 8) begin
        for (int h = 0; h < 4; h++) begin
          vecs[idx] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'(k), 8'(17 * (k + 1)), 1'b0,
                        (k == 7 && h == 3)};
          idx++;
        end
      end
    end

    reset_n = 1'b0;
    scan_en = 1'b0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    #3;
    check("reset_outputs", outs(), pack(1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
    reset_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      wr_req  = vecs[i].wr;
      wr_addr = vecs[i].wa;
      wr_data = vecs[i].wd;
      scan_en = vecs[i].en;
      tick();
      check($sformatf("scan_vec%0d", i), outs(),
            pack(vecs[i].ev, vecs[i].ea, vecs[i].ed, vecs[i].eack, vecs[i].efd));
    end

    // Writes stall FETCH for three cycles; fetch then returns the last written value.
    restart();
    scan_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      wr_req  = 1'b1;
      wr_addr = 3'd0;
      wr_data = 8'(8'hA1 + i);
      tick();
      check($sformatf("stall_ack%0d", i), {30'd0, wr_ack, disp_valid}, {30'd0, 1'b1, 1'b0});
    end
    wr_req = 1'b0;
    tick();
    check("stall_fetch", outs(), pack(1'b1, 3'd0, 8'hA3, 1'b0, 1'b0));

    // Write to the displayed entry during HOLD of address 2.
    restart();
    scan_en = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) tick();
    check("hold2_fetch", outs(), pack(1'b1, 3'd2, 8'h33, 1'b0, 1'b0));
`ifdef IMAGE_SCAN_WRBYPASS_EN
    exp_a5 = 8'hA5;
`else
    exp_a5 = 8'h33;
`endif
    wr_req  = 1'b1;
    wr_addr = 3'd2;
    wr_data = 8'hA5;
    tick();
    check("hold2_write", outs(), pack(1'b1, 3'd2, exp_a5, 1'b1, 1'b0));
    wr_addr = 3'd6;
    wr_data = 8'hEE;
    tick();
    check("other_addr_write", outs(), pack(1'b1, 3'd2, exp_a5, 1'b1, 1'b0));
    wr_req = 1'b0;
    for (int i = 0; i < 38; i++) tick();
    check("next_frame_addr2", outs(), pack(1'b1, 3'd2, 8'hA5, 1'b0, 1'b0));

    // scan_en dropped during HOLD of address 5, scan resumes at 0.
    restart();
    scan_en = 1'b1;
    tick();
    for (int i = 0; i < 27; i++) tick();
    check("hold5", outs(), pack(1'b1, 3'd5, 8'h66, 1'b0, 1'b0));
    scan_en = 1'b0;
    tick();
    check("drop_valid", {31'd0, disp_valid}, 32'd0);
    check("drop_keep_data", {24'd0, disp_data}, 32'h66);
    scan_en = 1'b1;
    tick();
    check("resume_idle", {31'd0, disp_valid}, 32'd0);
    tick();
    check("resume_addr0", outs(), pack(1'b1, 3'd0, 8'h11, 1'b0, 1'b0));

    // Asynchronous reset mid-HOLD, with a write held across a reset edge.
    restart();
    scan_en = 1'b1;
    tick();
    tick();
    tick();
    check("pre_reset_hold", outs(), pack(1'b1, 3'd0, 8'h11, 1'b0, 1'b0));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", outs(), pack(1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
    wr_req  = 1'b1;
    wr_addr = 3'd3;
    wr_data = 8'hFF;
    tick();
    check("reset_write_noack", {31'd0, wr_ack}, 32'd0);
    wr_req = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    check("post_reset_idle", outs(), pack(1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
    tick();
    check("post_reset_fetch0", outs(), pack(1'b1, 3'd0, 8'h00, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/image_scan_ctrl.md
IMAGE_SCAN_CTRL -- requirements
Module: image_scan_ctrl

Interface
REQ-001 Parameter RAM_WIDTH, default 8: image word width in bits, applies to wr_data and disp_data.
REQ-002 Parameter RAM_ADDR_BITS, default 3: image address width; depth = 2**RAM_ADDR_BITS entries.
REQ-003 Parameter DWELL_CYCLES, default 50000: number of cycles each entry is held on the display; legal range 1..65535.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 scan_en  in  1  scanning enabled while high.
REQ-007 wr_req  in  1  host write request.
REQ-008 wr_addr  in  RAM_ADDR_BITS  host write address.
REQ-009 wr_data  in  RAM_WIDTH  host write data.
REQ-010 wr_ack  out  1  one-cycle write-completed pulse.
REQ-011 disp_data  out  RAM_WIDTH  byte currently presented to the hex/seven-segment path.
REQ-012 disp_addr  out  RAM_ADDR_BITS  address of the entry in disp_data.
REQ-013 disp_valid  out  1  high when disp_data holds a fetched entry.
REQ-014 frame_done  out  1  one-cycle pulse on scan address wrap.

Function
REQ-015 The block SHALL contain the image store: 2**RAM_ADDR_BITS x RAM_WIDTH, single-port (one read or one write per cycle).
REQ-016 The block SHALL implement states IDLE, FETCH and HOLD.
REQ-017 IDLE: disp_valid=0; go to FETCH on the first edge with scan_en=1.
REQ-018 FETCH: with wr_req=0, read the store at the scan address, load disp_data/disp_addr on that edge, set disp_valid=1, load the dwell counter with DWELL_CYCLES-1 and go to HOLD (1-cycle read latency).
REQ-019 FETCH with wr_req=1: the write SHALL win, the read SHALL be deferred and the FSM SHALL stay in FETCH.
REQ-020 HOLD: decrement the dwell counter each cycle; at 0, advance the scan address by 1 and go to FETCH; HOLD lasts exactly DWELL_CYCLES cycles.
REQ-021 Scan address SHALL wrap from 2**RAM_ADDR_BITS-1 to 0; frame_done SHALL pulse on the wrap edge.
REQ-022 Any write with wr_req=1 SHALL be performed on that edge in every state, and wr_ack SHALL be 1 on the following cycle only; back-to-back writes are acked every cycle.
REQ-023 Continuous wr_req SHALL stall the scan indefinitely in FETCH; no fairness is provided.
REQ-024 scan_en=0 in any state SHALL return the FSM to IDLE on the next edge, clear disp_valid and reset the scan address to 0; disp_data keeps its last value.
REQ-025 A write to an address other than disp_addr SHALL NOT change disp_data.

Reset
REQ-026 reset_n low SHALL asynchronously force: FSM=IDLE, scan address=0, dwell counter=0, store contents=0, disp_data=0, disp_addr=0, disp_valid=0, wr_ack=0, frame_done=0.
REQ-027 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the scan; after release, scanning restarts at address 0.
REQ-028 A write coincident with reset assertion SHALL be discarded, with no wr_ack.

Configuration
REQ-029 Macro IMAGE_SCAN_WRBYPASS_EN defined: a write with wr_addr==disp_addr while disp_valid=1 SHALL also load wr_data into disp_data on the same edge.
REQ-030 Macro IMAGE_SCAN_WRBYPASS_EN undefined: such a write updates the store only; disp_data changes on the next fetch of that entry.

Verification (DWELL_CYCLES=4, defaults otherwise)
REQ-031 Reset, write 0x11..0x88 to addresses 0..7, then scan_en=1 -> disp_addr 0..7 with disp_data 0x11..0x88, each held 4 cycles with 5-cycle spacing; frame_done pulse on the 7->0 wrap.
REQ-032 wr_req=1 held 3 cycles while the FSM is in FETCH -> FETCH held 3 extra cycles, three wr_ack pulses, then the fetch completes with the written data if the address matches.
REQ-033 During HOLD of address 2 (0x33), write 0xA5 to address 2 -> disp_data becomes 0xA5 on the write edge with IMAGE_SCAN_WRBYPASS_EN, stays 0x33 until the next frame without it.
REQ-034 scan_en dropped during HOLD of address 5 -> next cycle disp_valid=0; on scan_en=1 the scan resumes at address 0.
REQ-035 reset_n pulsed low asynchronously between edges during HOLD -> all outputs 0 immediately, store reads back 0x00 on the following scan.
